// File: rtl/mbldcm_pkg.sv
// mbldcm_pkg: shared definitions for the BLDC commutator.
// Holds the frequency word width, the six-step phase constants, the
// commutator state encoding and a phase-advance helper.
package mbldcm_pkg;

    localparam int unsigned FREQ_W      = 32;
    localparam int unsigned PHASE_W     = 3;
    localparam int unsigned PHASE_COUNT = 6;
    localparam int unsigned PHASE_MAX   = PHASE_COUNT - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RAMP   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Next commutation step, wrapping from the last step back to 0.
    function automatic logic [PHASE_W-1:0] phase_next(input logic [PHASE_W-1:0] phase);
        return (phase == PHASE_W'(PHASE_MAX)) ? '0 : phase + PHASE_W'(1);
    endfunction

endpackage

// File: rtl/mbldcm_ramp_gen.sv
// mbldcm_ramp_gen: ramp-tick divider and slew limiter.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   target   in   effective target frequency
//   current  out  registered ramped frequency; moves toward target by at
//                 most ramp_step once every ramp_div cycles
module mbldcm_ramp_gen
    import mbldcm_pkg::*;
#(
    parameter int unsigned       ramp_div  = 1000,
    parameter logic [FREQ_W-1:0] ramp_step = 32'd64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FREQ_W-1:0] target,
    output logic [FREQ_W-1:0] current
);

    localparam int unsigned      CNT_W    = (ramp_div > 1) ? $clog2(ramp_div) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ramp_div - 1);

    logic [CNT_W-1:0]  tick_cnt;
    logic              tick_c;
    logic [FREQ_W-1:0] slewed_c;

    assign tick_c = (tick_cnt == CNT_LAST);

    // Step toward the target; the distance is always formed as the larger
    // minus the smaller operand so neither overshoot nor wrap can occur.
    always_comb begin
        slewed_c = current;
        if (target > current) begin
            if ((target - current) <= ramp_step) begin
                slewed_c = target;
            end else begin
                slewed_c = current + ramp_step;
            end
        end else if (current > target) begin
            if ((current - target) <= ramp_step) begin
                slewed_c = target;
            end else begin
                slewed_c = current - ramp_step;
            end
        end
    end

    // Free-running tick divider; current frequency only changes on a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            current  <= '0;
        end else begin
            tick_cnt <= tick_c ? '0 : tick_cnt + CNT_W'(1);
            if (tick_c) begin
                current <= slewed_c;
            end
        end
    end

endmodule

// File: rtl/mbldcm_commutator.sv
// mbldcm_commutator: six-step BLDC commutation sequencer.
// A slew-limited frequency drives a 32-bit phase accumulator; each
// accumulator carry advances the commutation step.
// Ports:
//   iClock             in   clock, rising edge
//   iReset             in   asynchronous active-high reset
//   iFreqTarget        in   target frequency word
//   iLatchFreqTarget   in   strobe loading iFreqTarget
//   iPhaseUpdate       in   forced commutation step (6/7 ignored)
//   iLatchPhaseUpdate  in   strobe applying iPhaseUpdate
//   iEnable            in   run enable; low ramps the motor down to 0
//   oFreqTarget        out  held target for readback
//   oFreqCurrent       out  ramped frequency (NCO increment)
//   oPhase             out  commutation step 0..5
//   oStep              out  one-cycle pulse per phase advance
//   oFreqReflected     out  high while locked on a nonzero target
//   oStop              out  high while stopped (idle)
module mbldcm_commutator
    import mbldcm_pkg::*;
#(
    parameter int unsigned       pRampDiv  = 1000,
    parameter logic [FREQ_W-1:0] pRampStep = 32'd64
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic [FREQ_W-1:0]  iFreqTarget,
    input  logic               iLatchFreqTarget,
    input  logic [PHASE_W-1:0] iPhaseUpdate,
    input  logic               iLatchPhaseUpdate,
    input  logic               iEnable,
    output logic [FREQ_W-1:0]  oFreqTarget,
    output logic [FREQ_W-1:0]  oFreqCurrent,
    output logic [PHASE_W-1:0] oPhase,
    output logic               oStep,
    output logic               oFreqReflected,
    output logic               oStop
);

    state_t            state;
    logic [FREQ_W-1:0] eff_target_c;
    logic [FREQ_W-1:0] acc;
    logic [FREQ_W:0]   acc_sum_c;
    logic              force_c;

    // Held target register for readback and ramp reference.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            oFreqTarget <= '0;
        end else if (iLatchFreqTarget) begin
            oFreqTarget <= iFreqTarget;
        end
    end

    assign eff_target_c = iEnable ? oFreqTarget : '0;

    mbldcm_ramp_gen #(
        .ramp_div  (pRampDiv),
        .ramp_step (pRampStep)
    ) u_ramp_gen (
        .clk     (iClock),
        .rst     (iReset),
        .target  (eff_target_c),
        .current (oFreqCurrent)
    );

    assign acc_sum_c = {1'b0, acc} + {1'b0, oFreqCurrent};
    assign force_c   = iLatchPhaseUpdate && (iPhaseUpdate <= PHASE_W'(PHASE_MAX));

    // Phase accumulator and step counter; a forced phase overrides a carry.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            acc    <= '0;
            oPhase <= '0;
            oStep  <= 1'b0;
        end else if (force_c) begin
            acc    <= '0;
            oPhase <= iPhaseUpdate;
            oStep  <= 1'b0;
        end else begin
            acc   <= acc_sum_c[FREQ_W-1:0];
            oStep <= acc_sum_c[FREQ_W];
            if (acc_sum_c[FREQ_W]) begin
                oPhase <= phase_next(oPhase);
            end
        end
    end

    // Run-state machine; status outputs are registered alongside the state.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state          <= ST_IDLE;
            oStop          <= 1'b1;
            oFreqReflected <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (eff_target_c != '0) begin
                        state <= ST_RAMP;
                        oStop <= 1'b0;
                    end
                end
                ST_RAMP: begin
                    if ((oFreqCurrent == eff_target_c) && (oFreqCurrent != '0)) begin
                        state          <= ST_LOCKED;
                        oFreqReflected <= 1'b1;
                    end else if ((oFreqCurrent == '0) && (eff_target_c == '0)) begin
                        state <= ST_IDLE;
                        oStop <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (eff_target_c != oFreqCurrent) begin
                        state          <= ST_RAMP;
                        oFreqReflected <= 1'b0;
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    oStop          <= 1'b1;
                    oFreqReflected <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mbldcm_commutator.sv
// tb_mbldcm_commutator: self-checking bench for mbldcm_commutator.
// Two instances share one stimulus stream: dut0 uses the slow ramp
// (step 16) and dut1 a step of 2^30 so it locks fast enough to exercise
// the phase accumulator carries.
module tb_mbldcm_commutator;

    localparam int     DIV    = 4;
    localparam longint STEP_A = 16;
    localparam longint STEP_B = 64'h4000_0000;
    localparam longint TWO32  = 64'h1_0000_0000;

    logic        iClock            = 1'b0;
    logic        iReset            = 1'b1;
    logic [31:0] iFreqTarget       = '0;
    logic        iLatchFreqTarget  = 1'b0;
    logic [2:0]  iPhaseUpdate      = '0;
    logic        iLatchPhaseUpdate = 1'b0;
    logic        iEnable           = 1'b0;

    logic [31:0] o_target [2];
    logic [31:0] o_cur    [2];
    logic [2:0]  o_phase  [2];
    logic        o_step   [2];
    logic        o_refl   [2];
    logic        o_stop   [2];

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    always #5 iClock = ~iClock;

    mbldcm_commutator #(.pRampDiv(DIV), .pRampStep(32'd16)) dut0 (
        .iClock(iClock), .iReset(iReset),
        .iFreqTarget(iFreqTarget), .iLatchFreqTarget(iLatchFreqTarget),
        .iPhaseUpdate(iPhaseUpdate), .iLatchPhaseUpdate(iLatchPhaseUpdate),
        .iEnable(iEnable),
        .oFreqTarget(o_target[0]), .oFreqCurrent(o_cur[0]), .oPhase(o_phase[0]),
        .oStep(o_step[0]), .oFreqReflected(o_refl[0]), .oStop(o_stop[0])
    );

    mbldcm_commutator #(.pRampDiv(DIV), .pRampStep(32'h4000_0000)) dut1 (
        .iClock(iClock), .iReset(iReset),
        .iFreqTarget(iFreqTarget), .iLatchFreqTarget(iLatchFreqTarget),
        .iPhaseUpdate(iPhaseUpdate), .iLatchPhaseUpdate(iLatchPhaseUpdate),
        .iEnable(iEnable),
        .oFreqTarget(o_target[1]), .oFreqCurrent(o_cur[1]), .oPhase(o_phase[1]),
        .oStep(o_step[1]), .oFreqReflected(o_refl[1]), .oStop(o_stop[1])
    );

    // ---------------- reference model ----------------
    // mode: 0 = stopped, 1 = slewing, 2 = holding on target
    longint m_target [2];
    longint m_cur    [2];
    longint m_acc    [2];
    int     m_cyc    [2];
    int     m_phase  [2];
    bit     m_step   [2];
    int     m_mode   [2];

    task automatic model_reset(input int k);
        m_target[k] = 0; m_cur[k] = 0; m_acc[k] = 0; m_cyc[k] = 0;
        m_phase[k] = 0; m_step[k] = 1'b0; m_mode[k] = 0;
    endtask

    task automatic model_clock(input int k);
        longint eff, stp, nxt, sum;
        stp = (k == 0) ? STEP_A : STEP_B;
        eff = iEnable ? m_target[k] : 0;
        nxt = m_cur[k];
        if (m_cyc[k] % DIV == DIV - 1) begin
            if (eff > m_cur[k]) nxt = (eff - m_cur[k] > stp) ? m_cur[k] + stp : eff;
            else                nxt = (m_cur[k] - eff > stp) ? m_cur[k] - stp : eff;
        end
        sum = m_acc[k] + m_cur[k];
        if (iLatchPhaseUpdate && iPhaseUpdate <= 3'd5) begin
            m_phase[k] = int'(iPhaseUpdate);
            m_acc[k]   = 0;
            m_step[k]  = 1'b0;
        end else begin
            m_acc[k]  = sum % TWO32;
            m_step[k] = (sum >= TWO32);
            if (m_step[k]) m_phase[k] = (m_phase[k] + 1) % 6;
        end
        if (m_mode[k] == 0) begin
            if (eff != 0) m_mode[k] = 1;
        end else if (m_mode[k] == 1) begin
            if (m_cur[k] == eff && eff != 0) m_mode[k] = 2;
            else if (m_cur[k] == 0 && eff == 0) m_mode[k] = 0;
        end else begin
            if (eff != m_cur[k]) m_mode[k] = 1;
        end
        if (iLatchFreqTarget) m_target[k] = longint'(iFreqTarget);
        m_cyc[k] = m_cyc[k] + 1;
        m_cur[k] = nxt;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) model_reset(k);
    end

    always @(posedge iClock or posedge iReset) begin
        for (int k = 0; k < 2; k++) begin
            if (iReset) model_reset(k);
            else        model_clock(k);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int k, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL dut%0d %s: got 0x%0h, want 0x%0h at %0t", k, name, act, exp, $time);
        end
    endtask

    always @(negedge iClock) begin
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("freq_target",  k, longint'(o_target[k]), m_target[k]);
                chk("freq_current", k, longint'(o_cur[k]),    m_cur[k]);
                chk("phase",        k, longint'(o_phase[k]),  longint'(m_phase[k]));
                chk("step",         k, longint'(o_step[k]),   longint'(m_step[k]));
                chk("stop",         k, longint'(o_stop[k]),   longint'(m_mode[k] == 0));
                chk("reflected",    k, longint'(o_refl[k]),   longint'(m_mode[k] == 2));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed helpers ----------------
    task automatic do_reset();
        @(negedge iClock);
        #2 iReset = 1'b1;
        repeat (2) @(negedge iClock);
        #2 iReset = 1'b0;
    endtask

    task automatic latch_target(input logic [31:0] v);
        @(negedge iClock);
        iFreqTarget      = v;
        iLatchFreqTarget = 1'b1;
        @(negedge iClock);
        iLatchFreqTarget = 1'b0;
    endtask

    // Track dut0's current frequency, checking each new value and the tick spacing.
    task automatic collect_ramp(input string name, input longint expv[7], input bit refl_drop);
        longint last;
        int idx, gap;
        last = longint'(o_cur[0]);
        idx = 0;
        gap = 0;
        for (int c = 0; c < 80 && idx < 7; c++) begin
            @(negedge iClock);
            gap++;
            if (c == 0 && refl_drop) chk("reflected_drop", 0, longint'(o_refl[0]), 0);
            if (longint'(o_cur[0]) != last) begin
                chk(name, 0, longint'(o_cur[0]), expv[idx]);
                if (idx > 0) chk("tick_gap", 0, longint'(gap), DIV);
                last = longint'(o_cur[0]);
                idx++;
                gap = 0;
            end
        end
        chk({name, "_count"}, 0, longint'(idx), 7);
    endtask

    longint up_seq   [7] = '{16, 32, 48, 64, 80, 96, 100};
    longint down_seq [7] = '{84, 68, 52, 36, 20, 4, 0};

    initial begin
        int pulses, gap;

        // ---- ramp up to 100 ----
        do_reset();
        check_en = 1'b1;
        chk("reset_stop",  0, longint'(o_stop[0]),  1);
        chk("reset_phase", 0, longint'(o_phase[0]), 0);
        iEnable = 1'b1;
        @(negedge iClock);
        iFreqTarget      = 32'd100;
        iLatchFreqTarget = 1'b1;
        @(negedge iClock);
        iLatchFreqTarget = 1'b0;
        chk("stop_at_latch", 0, longint'(o_stop[0]), 1);
        @(negedge iClock);
        chk("stop_fall", 0, longint'(o_stop[0]), 0);
        collect_ramp("ramp_up", up_seq, 1'b0);
        chk("reflected_at_100", 0, longint'(o_refl[0]), 0);
        @(negedge iClock);
        chk("reflected_locked", 0, longint'(o_refl[0]), 1);

        // ---- disable ramps down to stop ----
        iEnable = 1'b0;
        collect_ramp("ramp_down", down_seq, 1'b1);
        chk("stop_at_zero", 0, longint'(o_stop[0]), 0);
        @(negedge iClock);
        chk("stop_after_zero", 0, longint'(o_stop[0]),   1);
        chk("target_kept",     0, longint'(o_target[0]), 100);

        // ---- reset mid-ramp ----
        iEnable = 1'b1;
        for (int c = 0; c < 60 && o_cur[0] != 32'd48; c++) @(negedge iClock);
        chk("reach_48", 0, longint'(o_cur[0]), 48);
        #2 iReset = 1'b1;
        #1;
        chk("async_cur",    0, longint'(o_cur[0]),    0);
        chk("async_stop",   0, longint'(o_stop[0]),   1);
        chk("async_phase",  0, longint'(o_phase[0]),  0);
        chk("async_target", 0, longint'(o_target[0]), 0);
        chk("async_refl",   0, longint'(o_refl[0]),   0);
        chk("async_step",   0, longint'(o_step[0]),   0);
        chk("async_phase",  1, longint'(o_phase[1]),  0);
        chk("async_stop",   1, longint'(o_stop[1]),   1);
        repeat (2) @(negedge iClock);
        #2 iReset = 1'b0;
        latch_target(32'd100);
        collect_ramp("ramp_restart", up_seq, 1'b0);

        // ---- NCO on dut1: step every 4 cycles, phase 0..5 wrap ----
        do_reset();
        latch_target(32'h4000_0000);
        pulses = 0;
        gap = 0;
        for (int c = 0; c < 80 && pulses < 6; c++) begin
            @(negedge iClock);
            gap++;
            if (o_step[1]) begin
                chk("nco_phase", 1, longint'(o_phase[1]), longint'((pulses + 1) % 6));
                if (pulses > 0) chk("nco_gap", 1, longint'(gap), 4);
                pulses++;
                gap = 0;
            end
        end
        chk("nco_pulses",  1, longint'(pulses),    6);
        chk("nco_locked",  1, longint'(o_refl[1]), 1);
        chk("nco_current", 1, longint'(o_cur[1]),  STEP_B);

        // ---- forced phase on the carry edge ----
        repeat (3) @(negedge iClock);
        iPhaseUpdate      = 3'd3;
        iLatchPhaseUpdate = 1'b1;
        @(negedge iClock);
        iLatchPhaseUpdate = 1'b0;
        chk("force_phase", 1, longint'(o_phase[1]), 3);
        chk("force_step",  1, longint'(o_step[1]),  0);
        for (int i = 0; i < 4; i++) begin
            @(negedge iClock);
            chk("force_acc_cleared", 1, longint'(o_step[1]), longint'(i == 3));
        end
        chk("phase_after_force", 1, longint'(o_phase[1]), 4);
        iPhaseUpdate      = 3'd7;
        iLatchPhaseUpdate = 1'b1;
        @(negedge iClock);
        iLatchPhaseUpdate = 1'b0;
        chk("ignore_phase7", 1, longint'(o_phase[1]), 4);
        chk("ignore_step",   1, longint'(o_step[1]),  0);

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 3000; c++) begin
            @(negedge iClock);
            iLatchFreqTarget = ($urandom_range(0, 29) == 0);
            if (iLatchFreqTarget) begin
                case ($urandom_range(0, 3))
                    0:       iFreqTarget = '0;
                    1:       iFreqTarget = 32'($urandom_range(1, 200));
                    2:       iFreqTarget = 32'h4000_0000;
                    default: iFreqTarget = $urandom;
                endcase
            end
            if ($urandom_range(0, 59) == 0) iEnable = ~iEnable;
            iLatchPhaseUpdate = ($urandom_range(0, 14) == 0);
            iPhaseUpdate      = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 399) == 0) begin
                #2 iReset = 1'b1;
                @(negedge iClock);
                #2 iReset = 1'b0;
            end
        end
        @(negedge iClock);
        iLatchFreqTarget  = 1'b0;
        iLatchPhaseUpdate = 1'b0;
        repeat (2) @(negedge iClock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
